// File: rtl/hfrv_gpio_bank.sv
// hfrv_gpio_bank: memory-mapped GPIO bank for the HF-RISC data bus.
// PORTS ports of WIDTH bits. Each port has OUT, IN (2-flop synced), EDGE (sticky
// rise flags, W1C) and MASK registers. Reads return data one cycle after the address.

// Per-port state: output register, synchroniser, edge flags, mask, irq.
module hfrv_gpio_port #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             armed,
  input  logic [WIDTH-1:0] pin,
  input  logic             wr_out,
  input  logic             wr_edge,
  input  logic             wr_mask,
  input  logic [WIDTH-1:0] bmask,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] in_q,
  output logic [WIDTH-1:0] edge_q,
  output logic [WIDTH-1:0] mask_q,
  output logic             irq_nxt,
  output logic             irq
);
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;

  // rise is seen between the two synchroniser flops, so the flag lands with IN
  assign rise    = s1 & ~in_q;
  assign clr     = wr_edge ? (wdata & bmask) : '0;
  assign irq_nxt = |(edge_q & mask_q);

  // Port registers; the edge path ignores stall, writes arrive pre-qualified
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q  <= OUT_RESET;
      s1     <= '0;
      in_q   <= '0;
      edge_q <= '0;
      mask_q <= '0;
      irq    <= 1'b0;
    end else begin
      s1     <= pin;
      in_q   <= s1;
      // set term OR'd last so a same-cycle set beats the W1C clear
      edge_q <= (edge_q & ~clr) | (rise & {WIDTH{armed}});
      if (wr_out)  out_q  <= (out_q  & ~bmask) | (wdata & bmask);
      if (wr_mask) mask_q <= (mask_q & ~bmask) | (wdata & bmask);
      irq    <= irq_nxt;
    end
  end
endmodule

module hfrv_gpio_bank #(
  parameter int               WIDTH     = 8,
  parameter int               PORTS     = 2,
  parameter logic [31:0]      BASE_ADDR = 32'hE100_0000,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [31:0]            address,
  input  logic [31:0]            data_write,
  input  logic [3:0]             data_we,
  output logic [31:0]            data_read,
  input  logic [PORTS*WIDTH-1:0] extio_in,
  output logic [PORTS*WIDTH-1:0] extio_out,
  output logic [PORTS-1:0]       irq,
  output logic                   irq_any
);
  typedef enum logic [1:0] {R_OUT = 2'd0, R_IN = 2'd1, R_EDGE = 2'd2, R_MASK = 2'd3} reg_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] port;
    reg_e       rsel;
    logic       wr;
    logic       rd;
  } bus_req_t;

  bus_req_t                     req;
  logic [WIDTH-1:0]             bmask;
  logic [WIDTH-1:0]             wdata;
  logic [PORTS-1:0][WIDTH-1:0]  out_q, in_q, edge_q, mask_q;
  logic [PORTS-1:0]             irq_nxt;
  logic [1:0]                   warm;
  logic                         armed;
  logic [WIDTH-1:0]             rd_sel;
  logic [31:0]                  rd_word;
  logic                         unused;

  // low address bits and write data above WIDTH carry no information here
  assign unused = ^{address[1:0], data_write};

  // Decode the 64-byte window; ports beyond PORTS are holes
  always_comb begin
    req      = '0;
    req.hit  = (address[31:6] == BASE_ADDR[31:6]) && ({30'd0, address[5:4]} < 32'(PORTS));
    req.port = address[5:4];
    req.rsel = reg_e'(address[3:2]);
    req.wr   = req.hit && (data_we != 4'b0000) && !stall;
    req.rd   = req.hit && (data_we == 4'b0000);
  end

  assign wdata = data_write[WIDTH-1:0];

  // byte enables fanned out to register bits
  for (genvar i = 0; i < WIDTH; i++) begin : g_bmask
    assign bmask[i] = data_we[i/8];
  end

  // Warm-up: edges are not armed until the synchroniser holds real pin values
  always_ff @(posedge clk) begin
    if (!reset)              warm <= 2'd0;
    else if (warm != 2'd3)   warm <= warm + 2'd1;
  end
  assign armed = (warm == 2'd3);

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic sel;
    assign sel = req.wr && (req.port == 2'(p));

    hfrv_gpio_port #(.WIDTH(WIDTH), .OUT_RESET(OUT_RESET)) u_port (
      .clk     (clk),
      .reset   (reset),
      .armed   (armed),
      .pin     (extio_in[p*WIDTH +: WIDTH]),
      .wr_out  (sel && (req.rsel == R_OUT)),
      .wr_edge (sel && (req.rsel == R_EDGE)),
      .wr_mask (sel && (req.rsel == R_MASK)),
      .bmask   (bmask),
      .wdata   (wdata),
      .out_q   (out_q[p]),
      .in_q    (in_q[p]),
      .edge_q  (edge_q[p]),
      .mask_q  (mask_q[p]),
      .irq_nxt (irq_nxt[p]),
      .irq     (irq[p])
    );

    assign extio_out[p*WIDTH +: WIDTH] = out_q[p];
  end

  // Read mux over ports and registers, zero-extended to the bus width
  always_comb begin
    rd_sel  = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (req.port == 2'(p)) begin
        case (req.rsel)
          R_OUT:   rd_sel = out_q[p];
          R_IN:    rd_sel = in_q[p];
          R_EDGE:  rd_sel = edge_q[p];
          default: rd_sel = mask_q[p];
        endcase
      end
    end
    rd_word = '0;
    rd_word[WIDTH-1:0] = rd_sel;
  end

  // Registered read data; misses and writes return 0, stall freezes it
  always_ff @(posedge clk) begin
    if (!reset)      data_read <= 32'h0;
    else if (!stall) data_read <= req.rd ? rd_word : 32'h0;
  end

  // irq_any built from the same next-state as irq so both assert together
  always_ff @(posedge clk) begin
    if (!reset) irq_any <= 1'b0;
    else        irq_any <= |irq_nxt;
  end
endmodule

// File: tb/tb_hfrv_gpio_bank.sv
// Bench for hfrv_gpio_bank (WIDTH=8, PORTS=2, OUT_RESET=8'hA5).
module tb_hfrv_gpio_bank;
  localparam logic [31:0] BASE = 32'hE100_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] address;
  logic [31:0] data_write;
  logic [3:0]  data_we;
  logic [31:0] data_read;
  logic [15:0] extio_in;
  logic [15:0] extio_out;
  logic [1:0]  irq;
  logic        irq_any;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  hfrv_gpio_bank #(.WIDTH(8), .PORTS(2), .BASE_ADDR(BASE), .OUT_RESET(8'hA5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .address(address),
    .data_write(data_write), .data_we(data_we), .data_read(data_read),
    .extio_in(extio_in), .extio_out(extio_out), .irq(irq), .irq_any(irq_any)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    address    = a;
    data_write = d;
    data_we    = we;
  endtask

  task automatic idle();
    bus(32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; extio_in = 16'hFFFF; idle();
    tick(2);
    n_cmp++; if (extio_out !== 16'hA5A5) begin n_err++; $display("FAIL reset_out got %h exp %h", extio_out, 16'hA5A5); end
    n_cmp++; if (data_read !== 32'h0) begin n_err++; $display("FAIL reset_rd got %h exp 0", data_read); end
    n_cmp++; if (irq !== 2'b00 || irq_any !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b/%b exp 00/0", irq, irq_any); end
    reset = 1'b1;
    tick(6);
    // back-to-back reads of both EDGE registers: pins high through reset give no edge
    bus(BASE + 32'h08, 32'h0, 4'h0); sb.push_back(32'h0);
    tick();
    bus(BASE + 32'h18, 32'h0, 4'h0); sb.push_back(32'h0);
    e = sb.pop_front();
    n_cmp++; if (data_read !== e) begin n_err++; $display("FAIL reset_edge0 got %h exp %h", data_read, e); end
    tick();
    e = sb.pop_front();
    n_cmp++; if (data_read !== e) begin n_err++; $display("FAIL reset_edge1 got %h exp %h", data_read, e); end
    idle(); extio_in = 16'h0000;
    tick(3);
  endtask

  task automatic test_byte_write();
    bus(BASE + 32'h10, 32'h1234_5678, 4'b0001);
    tick();
    n_cmp++; if (extio_out[15:8] !== 8'h78) begin n_err++; $display("FAIL be_pin got %h exp 78", extio_out[15:8]); end
    bus(BASE + 32'h10, 32'h0, 4'h0); sb.push_back(32'h0000_0078);
    tick();
    e = sb.pop_front();
    n_cmp++; if (data_read !== e) begin n_err++; $display("FAIL be_read got %h exp %h", data_read, e); end
    // upper byte lanes only: nothing lands inside WIDTH
    bus(BASE + 32'h10, 32'hFFFF_FF00, 4'b1110);
    tick();
    bus(BASE + 32'h10, 32'h0, 4'h0); sb.push_back(32'h0000_0078);
    tick();
    e = sb.pop_front();
    n_cmp++; if (data_read !== e) begin n_err++; $display("FAIL be_upper got %h exp %h", data_read, e); end
    n_cmp++; if (extio_out !== 16'h78A5) begin n_err++; $display("FAIL be_pins got %h exp 78a5", extio_out); end
    idle();
  endtask

  task automatic test_edge_irq();
    bus(BASE + 32'h0C, 32'h0000_0001, 4'hF);
    tick();
    idle(); extio_in[0] = 1'b1;
    tick();  // edge k: s1
    tick();  // edge k+1: EDGE set
    n_cmp++; if (irq[0] !== 1'b0) begin n_err++; $display("FAIL edge_early_irq got %b exp 0", irq[0]); end
    tick();  // edge k+2: irq
    n_cmp++; if (irq !== 2'b01 || irq_any !== 1'b1) begin n_err++; $display("FAIL edge_irq got %b/%b exp 01/1", irq, irq_any); end
    bus(BASE + 32'h08, 32'h0, 4'h0); sb.push_back(32'h0000_0001);
    tick();
    e = sb.pop_front();
    n_cmp++; if (data_read !== e) begin n_err++; $display("FAIL edge_flag got %h exp %h", data_read, e); end
    bus(BASE + 32'h08, 32'h0000_0001, 4'hF);
    tick();  // EDGE clears here, irq still reflects old flag
    idle();
    n_cmp++; if (irq[0] !== 1'b1) begin n_err++; $display("FAIL w1c_irq_hold got %b exp 1", irq[0]); end
    tick();
    n_cmp++; if (irq !== 2'b00 || irq_any !== 1'b0) begin n_err++; $display("FAIL w1c_irq_fall got %b/%b exp 00/0", irq, irq_any); end
  endtask

  task automatic test_set_clear();
    extio_in[0] = 1'b0;
    tick(3);
    extio_in[0] = 1'b1;
    tick();  // s1 = 1, rise pending at next edge
    bus(BASE + 32'h08, 32'h0000_0001, 4'hF);
    tick();
    bus(BASE + 32'h08, 32'h0, 4'h0); sb.push_back(32'h0000_0001);
    tick();
    e = sb.pop_front();
    n_cmp++; if (data_read !== e) begin n_err++; $display("FAIL set_wins got %h exp %h", data_read, e); end
    bus(BASE + 32'h08, 32'h0000_0001, 4'hF);
    tick();
    bus(BASE + 32'h08, 32'h0, 4'h0); sb.push_back(32'h0);
    tick();
    e = sb.pop_front();
    n_cmp++; if (data_read !== e) begin n_err++; $display("FAIL clear_only got %h exp %h", data_read, e); end
    idle();
    tick(2);
  endtask

  task automatic test_stall();
    bus(BASE + 32'h00, 32'h0, 4'h0); sb.push_back(32'h0000_00A5);
    tick();
    e = sb.pop_front();
    n_cmp++; if (data_read !== e) begin n_err++; $display("FAIL pre_stall got %h exp %h", data_read, e); end
    stall = 1'b1;
    bus(BASE + 32'h00, 32'h0000_00FF, 4'hF);
    extio_in[1] = 1'b1;
    tick(3);
    n_cmp++; if (extio_out[7:0] !== 8'hA5) begin n_err++; $display("FAIL stall_wr got %h exp a5", extio_out[7:0]); end
    n_cmp++; if (data_read !== 32'h0000_00A5) begin n_err++; $display("FAIL stall_hold got %h exp a5", data_read); end
    stall = 1'b0;
    bus(BASE + 32'h08, 32'h0, 4'h0); sb.push_back(32'h0000_0002);
    tick();
    e = sb.pop_front();
    n_cmp++; if (data_read !== e) begin n_err++; $display("FAIL stall_edge got %h exp %h", data_read, e); end
    n_cmp++; if (irq !== 2'b00) begin n_err++; $display("FAIL stall_irq got %b exp 00", irq); end
    idle();
  endtask

  task automatic test_decode();
    bus(BASE + 32'h30, 32'hFFFF_FFFF, 4'hF);
    tick();
    bus(BASE + 32'h00, 32'h0, 4'h0); sb.push_back(32'h0000_00A5);
    tick();
    bus(BASE + 32'h20, 32'h0, 4'h0); sb.push_back(32'h0);
    e = sb.pop_front();
    n_cmp++; if (data_read !== e) begin n_err++; $display("FAIL dec_out0 got %h exp %h", data_read, e); end
    tick();
    bus(BASE - 32'h4, 32'h0, 4'h0); sb.push_back(32'h0);
    e = sb.pop_front();
    n_cmp++; if (data_read !== e) begin n_err++; $display("FAIL dec_port2 got %h exp %h", data_read, e); end
    tick();
    bus(BASE + 32'h1C, 32'h0, 4'h0); sb.push_back(32'h0);
    e = sb.pop_front();
    n_cmp++; if (data_read !== e) begin n_err++; $display("FAIL dec_below got %h exp %h", data_read, e); end
    tick();
    idle();
    e = sb.pop_front();
    n_cmp++; if (data_read !== e) begin n_err++; $display("FAIL dec_mask1 got %h exp %h", data_read, e); end
    n_cmp++; if (extio_out !== 16'h78A5) begin n_err++; $display("FAIL dec_pins got %h exp 78a5", extio_out); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain got %0d exp 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_edge_irq();
    test_set_clear();
    test_stall();
    test_decode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hfrv_gpio_bank.md
Name: hfrv_gpio_bank

Overview:
Parametrised memory-mapped GPIO bank on the HF-RISC data bus. It is the successor to the fixed 8-bit extio_in/extio_out pins and generalises them to PORTS ports of WIDTH bits each. Each port has an output register, a synchronised input, sticky rising-edge flags and an interrupt mask. The block decodes its own address window, returns read data with 1-cycle latency (sampled like the mem clocking block), and drives per-port and combined interrupt lines.

Parameters:
WIDTH, 8, bits per port; legal range 1..32.
PORTS, 2, number of ports; legal range 1..4.
BASE_ADDR, 32'hE100_0000, window base; must be 64-byte aligned.
OUT_RESET, 0, reset value of every OUT register; WIDTH bits, applied to all ports.

Ports:
clk  in  1  bus clock; all state updates on its rising edge
reset  in  1  synchronous, active-low; 0 at a clk rising edge resets the block
stall  in  1  CPU stall; when 1, bus writes are ignored and data_read holds its value
address  in  32  byte address from the CPU
data_write  in  32  write data
data_we  in  4  byte write enables; 4'b0000 means a read
data_read  out  32  registered read data
extio_in  in  PORTS*WIDTH  asynchronous input pins; port p occupies bits [p*WIDTH +: WIDTH]
extio_out  out  PORTS*WIDTH  output pins, driven directly from the OUT registers
irq  out  PORTS  per-port interrupt, registered
irq_any  out  1  OR of irq, registered

Behaviour:
- Address decode:
  - hit = (address[31:6] == BASE_ADDR[31:6]) && (address[5:4] < PORTS).
  - port = address[5:4]; reg = address[3:2]; address[1:0] is ignored.
- Register offsets within each port:
  - 0x0 OUT: read/write.
  - 0x4 IN: read-only; writes are ignored.
  - 0x8 EDGE: sticky flags, write-1-to-clear.
  - 0xC MASK: read/write.
- Width rules:
  - Bits [31:WIDTH] read as 0 and are ignored on writes.
  - A write applies only to the bytes whose data_we bit is 1; for EDGE, only the enabled bytes clear.
- Write condition: hit && data_we != 0 && stall == 0. The write takes effect at that clk edge; extio_out changes in the same cycle the register updates.
- Read behaviour:
  - When stall == 0, at each edge data_read <= the selected register value if hit && data_we == 0, otherwise 32'h0.
  - Read latency is 1 cycle: data_read is valid during the cycle after the address is presented.
  - When stall == 1, data_read holds its value.
- Input synchroniser: per bit, s1 <= extio_in, then IN <= s1. IN is the second flop.
- Edge detect: rise = s1 & ~IN; EDGE <= (EDGE & ~clear) | (rise & armed).
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
  - The edge path runs regardless of stall.
- Warm-up counter (2 bits):
  - Resets to 0 and increments each cycle until it saturates at 3; armed = (count == 3).
  - This prevents a pin that is already high at reset from raising a false edge.
- Interrupts:
  - irq[p] <= |(EDGE[p] & MASK[p]), registered one cycle after EDGE/MASK.
  - irq_any <= |(next irq), so irq_any asserts in the same cycle as irq.
- Pin-to-flag timing: a pin rising before edge k gives s1 = 1 after k, IN = 1 and EDGE = 1 after k+1, and irq = 1 after k+2.
- Reset (reset == 0 at an edge): every OUT = OUT_RESET; s1, IN, EDGE, MASK = 0; data_read = 0; irq = 0; irq_any = 0; warm-up counter = 0.
  - Reset in the middle of a transaction abandons it; no write is applied in that cycle.
- Accesses to offsets of non-existent ports (address[5:4] >= PORTS) read 0 and writes have no effect.

Test Plan:
- Reset check: WIDTH=8, PORTS=2, OUT_RESET=8'hA5. Hold reset low 2 cycles with extio_in all 1s -> extio_out=16'hA5A5, data_read=0, irq=0; after release, EDGE reads 0 for both ports (no false edge).
- Byte-enable write: write 32'h1234_5678 to BASE+0x10 (port1 OUT) with data_we=4'b0001 -> extio_out[15:8]=8'h78; read BASE+0x10 returns 32'h0000_0078 one cycle later; WIDTH masking of the upper bytes holds.
- Edge and interrupt: MASK0=8'h01, raise extio_in[0] before edge k -> EDGE0 bit0 set after k+1, irq[0]=1 and irq_any=1 after k+2; write 32'h1 to BASE+0x8 -> irq[0] falls the cycle after EDGE clears.
- Simultaneous set and clear: a new rise on bit0 in the same cycle as a W1C of bit0 -> EDGE bit0 stays 1.
- Stall: with stall=1, write 8'hFF to port0 OUT -> no change to extio_out and data_read holds; an edge on extio_in[1] during the stall still sets EDGE0 bit1.
- Decode boundary: PORTS=2, read BASE+0x20 and write BASE+0x30 -> read returns 0 and no state changes; read BASE-4 returns 0.
